// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch slice.
package fetch_pkg;

  localparam int FETCH_WIDTH = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Word index of a byte address, keeping only the low iw index bits.
  function automatic logic [FETCH_WIDTH-1:0] word_idx(input logic [FETCH_WIDTH-1:0] addr,
                                                      input int iw);
    logic [FETCH_WIDTH-1:0] mask;
    mask = FETCH_WIDTH'((64'd1 << iw) - 64'd1);
    return (addr >> $clog2(INSTR_BYTES)) & mask;
  endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush; head entry is read straight from registered storage.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 2 * FETCH_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & !empty & !flush;
  // A full FIFO may still accept a write when the head leaves in the same cycle.
  assign push_ok = push & !flush & (!full | pop_ok);
  assign rdata   = storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) storage[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: word-index PC driving imem, prefetch FIFO, valid/ready output, redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = FETCH_WIDTH,
  parameter int               SIZE     = 64,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] imem_a,
  input  logic [WIDTH-1:0] imem_rd,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc
);

  localparam int            IW        = $clog2(SIZE);
  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] RESET_IDX = IW'(word_idx(RESET_PC, IW));

  logic [IW-1:0]      pc_idx;
  logic [CW-1:0]      count;
  logic               empty;
  logic               pop;
  logic               push;
  logic [2*WIDTH-1:0] head;

  assign imem_a      = {{(WIDTH-IW-2){1'b0}}, pc_idx, 2'b00};
  assign instr_valid = !empty;
  assign pop         = instr_valid & instr_ready;
  assign push        = !redirect_valid & ((count < CW'(DEPTH)) | pop);

  // The index counter wraps naturally at SIZE because it is exactly IW bits wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_idx <= RESET_IDX;
    end else if (redirect_valid) begin
      pc_idx <= IW'(word_idx(redirect_pc, IW));
    end else if (push) begin
      pc_idx <= pc_idx + IW'(1);
    end
  end

  sync_fifo #(
    .WIDTH(2 * WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_a, imem_rd}),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  assign instr_pc   = empty ? '0 : head[2*WIDTH-1:WIDTH];
  assign instr_data = empty ? '0 : head[WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected {pc, instr} entries plus directed checks.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int IW    = 6;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  logic [31:0]  mem [64];
  fetch_entry_t q[$];
  logic [IW-1:0] m_pc = '0;
  int checks   = 0;
  int failures = 0;
  logic [96:0] observed;

  fetch_unit #(.WIDTH(32), .SIZE(64), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
  assign imem_rd  = mem[imem_a[IW+1:2]];
  assign observed = {instr_valid, instr_pc, instr_data, imem_a};

  function automatic logic [96:0] model_outputs();
    logic [31:0] a;
    a = {24'b0, m_pc, 2'b00};
    if (q.size() == 0) return {1'b0, 64'b0, a};
    return {1'b1, q[0].pc, q[0].instr, a};
  endfunction

  // Advance one clock and update the reference model from the inputs held during that cycle.
  task automatic tick();
    logic pop, push;
    pop  = (q.size() > 0) && instr_ready;
    push = !redirect_valid && ((q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      m_pc = '0;
    end else if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc[IW+1:2];
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: {24'b0, m_pc, 2'b00}, instr: 32'hA000_0000 + 32'(m_pc)});
        m_pc = m_pc + 1'b1;
      end
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0 || imem_a !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_state actual v=%b d=%h pc=%h a=%h required v=0 d=0 pc=0 a=0",
               instr_valid, instr_data, instr_pc, imem_a);
    end
  endtask

  task automatic test_stream();
    reset = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (observed !== model_outputs()) begin
        failures++;
        $display("[TB] FAIL stream[%0d] actual=%h required=%h", i, observed, model_outputs());
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'(4*(i-1)) || instr_data !== 32'hA000_0000 + 32'(i-1)) begin
          failures++;
          $display("[TB] FAIL stream_head[%0d] actual v=%b pc=%h d=%h required v=1 pc=%h d=%h",
                   i, instr_valid, instr_pc, instr_data, 32'(4*(i-1)), 32'hA000_0000 + 32'(i-1));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] nxt;
    reset = 1'b1; tick(); reset = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (observed !== model_outputs()) begin
        failures++;
        $display("[TB] FAIL bp_fill[%0d] actual=%h required=%h", i, observed, model_outputs());
      end
      tick();
    end
    checks++;
    if (imem_a !== 32'h10 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL bp_saturate actual a=%h v=%b pc=%h required a=00000010 v=1 pc=00000000",
               imem_a, instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    nxt = 32'h0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (observed !== model_outputs() || instr_pc !== nxt || instr_data !== 32'hA000_0000 + (nxt >> 2)) begin
        failures++;
        $display("[TB] FAIL bp_drain[%0d] actual=%h required=%h next_pc=%h", i, observed, model_outputs(), nxt);
      end
      nxt = nxt + 32'd4;
      tick();
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    do_redirect(32'h80);
    checks++;
    if (instr_valid !== 1'b0 || observed !== model_outputs()) begin
      failures++;
      $display("[TB] FAIL redirect_bubble actual=%h required=%h", observed, model_outputs());
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (observed !== model_outputs() || instr_pc !== 32'h80 + 32'(4*i) || instr_data !== 32'hA000_0020 + 32'(i)) begin
        failures++;
        $display("[TB] FAIL redirect_head[%0d] actual=%h required pc=%h d=%h", i, observed,
                 32'h80 + 32'(4*i), 32'hA000_0020 + 32'(i));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hF8; exp_pc[1] = 32'hFC; exp_pc[2] = 32'h00;
    do_redirect(32'hF8);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (observed !== model_outputs() || instr_pc !== exp_pc[i] ||
          instr_data !== 32'hA000_0000 + (exp_pc[i] >> 2)) begin
        failures++;
        $display("[TB] FAIL wrap[%0d] actual pc=%h d=%h required pc=%h d=%h", i, instr_pc, instr_data,
                 exp_pc[i], 32'hA000_0000 + (exp_pc[i] >> 2));
      end
      tick();
    end
  endtask

  // With 64 words only address bits [7:2] select the word, so 0x1000_0106 lands on index 1.
  task automatic test_misaligned();
    do_redirect(32'h1000_0106);
    tick();
    checks++;
    if (observed !== model_outputs() || instr_pc !== 32'h04 || instr_data !== 32'hA000_0001) begin
      failures++;
      $display("[TB] FAIL misaligned actual pc=%h d=%h required pc=00000004 d=a0000001", instr_pc, instr_data);
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    do_redirect(32'h20);
    repeat (3) tick();
    checks++;
    if (observed !== model_outputs() || q.size() != 3) begin
      failures++;
      $display("[TB] FAIL mid_fill actual=%h required=%h entries=%0d", observed, model_outputs(), q.size());
    end
    reset = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || imem_a !== 32'h0 || instr_pc !== 32'h0 || instr_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset actual v=%b a=%h pc=%h d=%h required v=0 a=0 pc=0 d=0",
               instr_valid, imem_a, instr_pc, instr_data);
    end
    reset = 1'b0; instr_ready = 1'b1;
    tick();
    checks++;
    if (observed !== model_outputs() || instr_pc !== 32'h0 || instr_data !== 32'hA000_0000) begin
      failures++;
      $display("[TB] FAIL mid_restart actual pc=%h d=%h required pc=00000000 d=a0000000", instr_pc, instr_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      checks++;
      if (observed !== model_outputs()) begin
        failures++;
        $display("[TB] FAIL random[%0d] actual=%h required=%h", i, observed, model_outputs());
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
